// File: rtl/pri_voq_req_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pri_voq_req_gen_if                                                          |
// | Arrival, request/decision and dequeue signals of the VOQ request generator. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface pri_voq_req_gen_if #(
  parameter int N = 8,
  parameter int P = 4
);
  localparam int DW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic [N-1:0]                   arr_valid;
  logic [N-1:0][DW-1:0]           arr_dst;
  logic [N-1:0][PW-1:0]           arr_pri;
  logic                           start;
  logic [0:N-1][0:N-1][PW-1:0]    pri_req_out;
  logic [N-1:0][N-1:0]            decision;
  logic                           decision_ready;
  logic [N-1:0]                   deq_valid;
  logic [N-1:0][DW-1:0]           deq_dst;
  logic [N-1:0][PW-1:0]           deq_pri;
  logic [N-1:0]                   drop_err;
  logic                           grant_err;

  // master: cell source and scheduler side; slave: the request generator
  modport master (
    output arr_valid, arr_dst, arr_pri, decision, decision_ready,
    input  start, pri_req_out, deq_valid, deq_dst, deq_pri, drop_err, grant_err
  );

  modport slave (
    input  arr_valid, arr_dst, arr_pri, decision, decision_ready,
    output start, pri_req_out, deq_valid, deq_dst, deq_pri, drop_err, grant_err
  );
endinterface
`default_nettype wire

// File: rtl/pri_voq_req_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pri_voq_req_gen                                                             |
// | Per-(input,output,level) cell counters feeding a priority request matrix to |
// | a crossbar scheduler. Optional aging promotion: define PRI_REQ_AGING_EN.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pri_voq_req_gen #(
  parameter int N         = 8,
  parameter int P         = 4,
  parameter int DEPTH     = 15,
  parameter int AGE_LIMIT = 7
) (
  input wire logic          clk,
  input wire logic          reset,
  pri_voq_req_gen_if.slave  bus
);
  localparam int DW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] TOP_LVL = PW'(P - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DEQ} state_t;

  state_t         state, state_nxt;
  logic           do_issue, do_deq;
  logic           any_nz;
  logic [CW-1:0]  cnt     [N][N][1:P-1];
  logic [CW-1:0]  cnt_nxt [N][N][1:P-1];
  logic [PW-1:0]  lvl     [N][N];
  logic [PW-1:0]  pres    [N][N];
  logic [PW-1:0]  snap    [N][N];
  logic [N-1:0]   sel_vld;
  logic [DW-1:0]  sel_dst [N];
  logic           grant_err_nxt;
  logic [N-1:0]   drop_nxt;

  always_comb begin
    state_nxt = state;
    do_issue  = 1'b0;
    do_deq    = 1'b0;
    case (state)
      IDLE:  if (any_nz) state_nxt = ISSUE;
      ISSUE: begin
        do_issue  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (bus.decision_ready) begin
        do_deq    = 1'b1;
        state_nxt = DEQ;
      end
      DEQ:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Live highest nonzero level per VOQ.
  always_comb begin
    any_nz = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        lvl[i][j] = '0;
        for (int p = 1; p < P; p++) begin
          if (cnt[i][j][p] != '0) begin
            lvl[i][j] = PW'(p);
            any_nz    = 1'b1;
          end
        end
      end
    end
  end

`ifdef PRI_REQ_AGING_EN
  localparam int AW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
  localparam logic [AW-1:0] AGE_C = AW'(AGE_LIMIT);

  logic [AW-1:0] age [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pres[i][j] = lvl[i][j];
        if (lvl[i][j] != '0 && age[i][j] >= AGE_C) pres[i][j] = TOP_LVL;
      end
    end
  end

  // Age only VOQs that competed in this round; a served VOQ starts over.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          age[i][j] <= '0;
    end else if (do_deq) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (snap[i][j] != '0) begin
            if (sel_vld[i] && sel_dst[i] == DW'(j)) age[i][j] <= '0;
            else if (age[i][j] < AGE_C)             age[i][j] <= age[i][j] + 1'b1;
          end
        end
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        pres[i][j] = lvl[i][j];
  end

  if (AGE_LIMIT < 0) begin : g_age_unused
  end
`endif

  // Lowest granted column per row is served if its snapshot is nonzero;
  // every other grant in the row, and an empty-snapshot grant, is an error.
  always_comb begin
    grant_err_nxt = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic hit;
      hit        = 1'b0;
      sel_vld[i] = 1'b0;
      sel_dst[i] = '0;
      for (int j = 0; j < N; j++) begin
        if (bus.decision[i][j]) begin
          if (hit) begin
            grant_err_nxt = 1'b1;
          end else begin
            hit = 1'b1;
            if (snap[i][j] != '0) begin
              sel_vld[i] = 1'b1;
              sel_dst[i] = DW'(j);
            end else begin
              grant_err_nxt = 1'b1;
            end
          end
        end
      end
    end
  end

  // Counter update; a same-cycle dequeue cancels the arrival, so a full
  // counter being dequeued never drops.
  always_comb begin
    drop_nxt = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        for (int p = 1; p < P; p++) begin
          logic inc, dec;
          inc = bus.arr_valid[i] && bus.arr_dst[i] == DW'(j) && bus.arr_pri[i] == PW'(p);
          dec = do_deq && sel_vld[i] && sel_dst[i] == DW'(j) && snap[i][j] == PW'(p);
          cnt_nxt[i][j][p] = cnt[i][j][p];
          if (inc && !dec) begin
            if (cnt[i][j][p] == DEPTH_C) drop_nxt[i] = 1'b1;
            else                         cnt_nxt[i][j][p] = cnt[i][j][p] + 1'b1;
          end else if (dec && !inc) begin
            cnt_nxt[i][j][p] = cnt[i][j][p] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      bus.start       <= 1'b0;
      bus.pri_req_out <= '0;
      bus.deq_valid   <= '0;
      bus.deq_dst     <= '0;
      bus.deq_pri     <= '0;
      bus.drop_err    <= '0;
      bus.grant_err   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          snap[i][j] <= '0;
          for (int p = 1; p < P; p++) cnt[i][j][p] <= '0;
        end
      end
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.start     <= do_issue;
      bus.drop_err  <= drop_nxt;
      bus.grant_err <= do_deq && grant_err_nxt;
      bus.deq_valid <= do_deq ? sel_vld : '0;
      if (do_issue) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            snap[i][j]            <= lvl[i][j];
            bus.pri_req_out[i][j] <= pres[i][j];
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        bus.deq_dst[i] <= (do_deq && sel_vld[i]) ? sel_dst[i] : '0;
        bus.deq_pri[i] <= (do_deq && sel_vld[i]) ? snap[i][sel_dst[i]] : '0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pri_voq_req_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pri_voq_req_gen                                                          |
// | Directed vector table plus hand-written multi-round sequences.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pri_voq_req_gen;
  localparam int N = 8, P = 4, DEPTH = 15, AGE_LIMIT = 7;
  localparam int DW = 3, PW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  pri_voq_req_gen_if #(.N(N), .P(P)) bus ();

  pri_voq_req_gen #(.N(N), .P(P), .DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ai, aj, ap;
    int gi, gj;
    bit exp_start;
    int exp_req;
    bit exp_deq;
    bit exp_gerr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.arr_valid      = '0;
    bus.arr_dst        = '0;
    bus.arr_pri        = '0;
    bus.decision       = '0;
    bus.decision_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic arrive(input int i, input int j, input int p);
    bus.arr_valid[i] = 1'b1;
    bus.arr_dst[i]   = DW'(j);
    bus.arr_pri[i]   = PW'(p);
    @(negedge clk);
    bus.arr_valid = '0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (bus.start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " start"}, 64'(bus.start), 64'd1);
  endtask

  task automatic no_start(input string name, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.start === 1'b1) seen++;
    end
    chk({name, " no start"}, 64'(seen), 64'd0);
  endtask

  // gi < 0 means decision_ready with an all-zero grant matrix.
  task automatic grant(input string name, input int gi, input int gj,
                       input bit exp_deq, input int exp_pri, input bit exp_gerr);
    logic [N-1:0] m;
    bus.decision = '0;
    if (gi >= 0) bus.decision[gi][gj] = 1'b1;
    bus.decision_ready = 1'b1;
    @(negedge clk);
    bus.decision       = '0;
    bus.decision_ready = 1'b0;
    m = '0;
    if (exp_deq) m[gi] = 1'b1;
    chk({name, " deq_valid"}, 64'(bus.deq_valid), 64'(m));
    if (exp_deq) begin
      chk({name, " deq_dst"}, 64'(bus.deq_dst[gi]), 64'(gj));
      chk({name, " deq_pri"}, 64'(bus.deq_pri[gi]), 64'(exp_pri));
    end
    chk({name, " grant_err"}, 64'(bus.grant_err), 64'(exp_gerr));
    chk({name, " start low"}, 64'(bus.start), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aged_req;
`ifdef PRI_REQ_AGING_EN
    aged_req = 3;
`else
    aged_req = 1;
`endif
    //          ai aj ap  gi gj  start req deq gerr
    vecs[0] = '{2, 5, 3,  2, 5,  1'b1, 3, 1'b1, 1'b0};
    vecs[1] = '{0, 7, 1,  0, 7,  1'b1, 1, 1'b1, 1'b0};
    vecs[2] = '{7, 0, 2,  7, 0,  1'b1, 2, 1'b1, 1'b0};
    vecs[3] = '{3, 3, 2,  3, 4,  1'b1, 2, 1'b0, 1'b1};
    vecs[4] = '{5, 1, 1,  4, 4,  1'b1, 1, 1'b0, 1'b1};
    vecs[5] = '{6, 6, 0,  0, 0,  1'b0, 0, 1'b0, 1'b0};

    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset start",       64'(bus.start),          64'd0);
    chk("reset deq_valid",   64'(bus.deq_valid),      64'd0);
    chk("reset drop_err",    64'(bus.drop_err),       64'd0);
    chk("reset grant_err",   64'(bus.grant_err),      64'd0);
    chk("reset pri_req_out", 64'(|bus.pri_req_out),   64'd0);
    reset = 1'b1;

    for (int k = 0; k < 6; k++) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      do_reset();
      arrive(vecs[k].ai, vecs[k].aj, vecs[k].ap);
      if (vecs[k].exp_start) begin
        wait_start(nm);
        chk({nm, " req"}, 64'(bus.pri_req_out[vecs[k].ai][vecs[k].aj]), 64'(vecs[k].exp_req));
        grant(nm, vecs[k].gi, vecs[k].gj, vecs[k].exp_deq, vecs[k].ap, vecs[k].exp_gerr);
        if (vecs[k].exp_deq) no_start({nm, " empty"}, 10);
      end else begin
        no_start(nm, 10);
      end
    end

    // Two levels in one VOQ: higher one first, lower one next round.
    do_reset();
    arrive(0, 0, 1);
    arrive(0, 0, 3);
    wait_start("lvl r1");
    chk("lvl r1 req", 64'(bus.pri_req_out[0][0]), 64'd3);
    grant("lvl r1", 0, 0, 1'b1, 3, 1'b0);
    wait_start("lvl r2");
    chk("lvl r2 req", 64'(bus.pri_req_out[0][0]), 64'd1);
    grant("lvl r2", 0, 0, 1'b1, 1, 1'b0);
    no_start("lvl empty", 10);

    // Saturation at DEPTH, then a same-cycle arrival+dequeue on the full counter.
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      arrive(1, 1, 2);
      chk($sformatf("sat arr%0d drop", n), 64'(bus.drop_err[1]), 64'(n == 16));
    end
    bus.arr_valid[1] = 1'b1;
    bus.arr_dst[1]   = 3'd1;
    bus.arr_pri[1]   = 2'd2;
    grant("sat full", 1, 1, 1'b1, 2, 1'b0);
    bus.arr_valid = '0;
    chk("sat arr+deq drop", 64'(bus.drop_err[1]), 64'd0);
    for (int n = 0; n < 15; n++) begin
      wait_start($sformatf("sat r%0d", n));
      chk($sformatf("sat r%0d req", n), 64'(bus.pri_req_out[1][1]), 64'd2);
      grant($sformatf("sat r%0d", n), 1, 1, 1'b1, 2, 1'b0);
    end
    no_start("sat empty", 10);

    // Arrival during WAIT must not disturb the presented snapshot.
    do_reset();
    arrive(6, 2, 1);
    wait_start("hold r1");
    chk("hold r1 req", 64'(bus.pri_req_out[6][2]), 64'd1);
    arrive(6, 2, 3);
    repeat (2) @(negedge clk);
    chk("hold wait req", 64'(bus.pri_req_out[6][2]), 64'd1);
    grant("hold r1", 6, 2, 1'b1, 1, 1'b0);
    wait_start("hold r2");
    chk("hold r2 req", 64'(bus.pri_req_out[6][2]), 64'd3);
    grant("hold r2", 6, 2, 1'b1, 3, 1'b0);
    no_start("hold empty", 10);

    // Reset in WAIT aborts the round and empties the counters.
    do_reset();
    arrive(2, 2, 2);
    wait_start("abort");
    bus.decision[2][2] = 1'b1;
    bus.decision_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    idle_inputs();
    chk("abort deq_valid", 64'(bus.deq_valid), 64'd0);
    chk("abort req", 64'(bus.pri_req_out[2][2]), 64'd0);
    @(negedge clk);
    chk("abort deq_valid late", 64'(bus.deq_valid), 64'd0);
    reset = 1'b1;
    no_start("abort empty", 10);

    // Seven denied rounds for VOQ (3,0) level 1, then the eighth round.
    do_reset();
    arrive(3, 0, 1);
    for (int n = 0; n < 7; n++) begin
      wait_start($sformatf("age r%0d", n));
      chk($sformatf("age r%0d req", n), 64'(bus.pri_req_out[3][0]), 64'd1);
      grant($sformatf("age r%0d", n), -1, 0, 1'b0, 0, 1'b0);
    end
    wait_start("age r7");
    chk("age r7 req", 64'(bus.pri_req_out[3][0]), 64'(aged_req));
    grant("age r7", 3, 0, 1'b1, 1, 1'b0);
    no_start("age empty", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pri_voq_req_gen.md
PRI_VOQ_REQ_GEN -- requirements
Module: pri_voq_req_gen

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the switch port count (inputs = outputs = N).
REQ-002 The block SHALL have parameter P, default 4, meaning the number of priority codes; code 0 = no request, codes 1..P-1 = levels, higher more urgent.
REQ-003 The block SHALL have parameter DEPTH, default 15, meaning the maximum cell count per (input, output, level) counter.
REQ-004 The block SHALL have parameter AGE_LIMIT, default 7, meaning the denied-round threshold for aging promotion.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-007 The block SHALL have port arr_valid, input, [N-1:0], a per-input cell arrival strobe.
REQ-008 The block SHALL have port arr_dst, input, [N-1:0][$clog2(N)-1:0], the arrival destination output.
REQ-009 The block SHALL have port arr_pri, input, [N-1:0][$clog2(P)-1:0], the arrival priority code.
REQ-010 The block SHALL have port start, output, 1, a one-cycle pulse launching a scheduling round.
REQ-011 The block SHALL have port pri_req_out, output, [0:N-1][0:N-1] of [$clog2(P)-1:0], the per-VOQ priority request to the scheduler.
REQ-012 The block SHALL have port decision, input, [N-1:0][N-1:0], the grant matrix where decision[i][j] grants input i to output j.
REQ-013 The block SHALL have port decision_ready, input, 1, asserted by the scheduler when decision is valid.
REQ-014 The block SHALL have port deq_valid, output, [N-1:0], a one-cycle per-input dequeue pulse.
REQ-015 The block SHALL have port deq_dst, output, [N-1:0][$clog2(N)-1:0], the granted output for each dequeuing input.
REQ-016 The block SHALL have port deq_pri, output, [N-1:0][$clog2(P)-1:0], the level dequeued for each input.
REQ-017 The block SHALL have port drop_err, output, [N-1:0], a one-cycle pulse on a dropped arrival.
REQ-018 The block SHALL have port grant_err, output, 1, a one-cycle pulse on a grant to an empty VOQ.

Function
REQ-019 Counters cnt[i][j][p] SHALL exist for p = 1..P-1, each $clog2(DEPTH+1) bits wide and saturating at DEPTH.
REQ-020 An arrival with arr_pri = 0 SHALL be ignored; an arrival to a counter at DEPTH SHALL be dropped and SHALL pulse drop_err[i] in the next cycle.
REQ-021 An arrival and a dequeue on the same counter in the same cycle SHALL leave it unchanged; a dropped arrival SHALL NOT occur when a same-cycle dequeue frees space.
REQ-022 The FSM SHALL have the states IDLE, ISSUE, WAIT and DEQ.
REQ-023 IDLE SHALL transition to ISSUE when any counter is nonzero.
REQ-024 In ISSUE, the block SHALL snapshot pri_req_out[i][j] as the highest nonzero level of VOQ (i,j), or 0 if the VOQ is empty, SHALL pulse start for exactly one cycle, and SHALL go to WAIT.
REQ-025 In WAIT, pri_req_out SHALL be held stable regardless of arrivals, and the FSM SHALL go to DEQ on the first cycle decision_ready = 1.
REQ-026 In DEQ, for each decision[i][j] = 1 whose snapshot is nonzero, the block SHALL decrement cnt[i][j][snapshot] and pulse deq_valid[i], deq_dst[i] = j and deq_pri[i] = snapshot for one cycle, then return to IDLE.
REQ-027 In DEQ, a grant whose snapshot is 0 SHALL be ignored and SHALL pulse grant_err.
REQ-028 If row i has multiple grants, the lowest j SHALL be served and the others SHALL pulse grant_err.
REQ-029 The round latency SHALL be: start one cycle after leaving IDLE, and deq_valid one cycle after decision_ready is sampled.

Reset
REQ-030 While reset = 0 at a clock edge, all counters, the snapshot and the age counters SHALL clear; the FSM SHALL go to IDLE; and start, pri_req_out, deq_*, drop_err and grant_err SHALL be 0.
REQ-031 A reset asserted during WAIT or DEQ SHALL abort the round with no dequeue pulses.

Configuration
REQ-032 With PRI_REQ_AGING_EN defined, per-VOQ age counters SHALL increment when a nonzero-snapshot VOQ is not granted in DEQ and clear on a grant; when an age counter reaches AGE_LIMIT, ISSUE SHALL present P-1 for that VOQ while deq_pri reports the real level dequeued.
REQ-033 Without PRI_REQ_AGING_EN, no age logic SHALL exist and snapshots SHALL be pure highest-level values.

Verification
REQ-034 Bench scenario: one arrival, input 2 to output 5, level 3, then decision[2][5] at decision_ready -> pri_req_out[2][5] = 3, one start pulse, deq_valid[2] with deq_dst = 5 and deq_pri = 3, counter returns to 0.
REQ-035 Bench scenario: levels 1 and 3 queued at (0,0) -> first round dequeues level 3, second round presents level 1.
REQ-036 Bench scenario: 16 arrivals at (1,1) level 2 with DEPTH = 15 -> the 16th pulses drop_err[1] and the count stays 15.
REQ-037 Bench scenario: grant to (4,4) with an empty VOQ -> grant_err pulses and no deq_valid.
REQ-038 Bench scenario: arrival during WAIT -> pri_req_out unchanged until the next ISSUE.
REQ-039 Bench scenario: with PRI_REQ_AGING_EN defined, VOQ (3,0) level 1 is denied 7 rounds -> the 8th round presents 3.
